// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline stage register:
//   - stage state encodings (2-bit; 2'b11 is illegal and recovers to EMPTY)
//   - default control/data bundle widths
//   - saturating increment helper used by the performance counters
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'b00;  // no entry held
  localparam logic [1:0] ST_FULL  = 2'b01;  // main entry only
  localparam logic [1:0] ST_SKID  = 2'b10;  // main and skid entries held

  localparam int unsigned CTRL_W_DEF = 32'd16;
  localparam int unsigned DATA_W_DEF = 32'd128;

  // Increment val, holding at the all-ones value of a width-bit counter.
  // Works for counters up to 64 bits wide.
  function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                          input int unsigned width);
    logic [63:0] max_v;
    if (width >= 32'd64) begin
      max_v = {64{1'b1}};
    end else begin
      max_v = (64'd1 << width) - 64'd1;
    end
    if (val >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = val + 64'd1;
    end
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// ---------------------------------------------------------------------------
// pipe_sat_counter
// Saturating event counter: counts INC pulses, sticks at all-ones, and
// clears only on RESET.
// Ports:
//   CLK    in   clock, rising edge
//   RESET  in   synchronous active-high clear
//   INC    in   count enable for this edge
//   COUNT  out  registered count value (CNT_W bits, at most 64)
// ---------------------------------------------------------------------------
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             INC,
  output logic [CNT_W-1:0] COUNT
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Next count: saturating increment when enabled, otherwise hold.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (INC) begin
      cnt_nxt_s = CNT_W'(sat_inc(64'(cnt_r), CNT_W));
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign COUNT = cnt_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Elastic pipeline stage register with a 2-entry skid buffer. Carries an
// opaque control bundle (zeroed on bubbles) and a data bundle (left stale on
// bubbles) under a valid/ready handshake. IN_READY depends only on held
// state plus BUSYWAIT/RESET, never on OUT_READY.
// Edge priority: RESET > FLUSH > BUSYWAIT > handshake.
// Optional feature macro: PIPE_PERF_CNT_EN adds STALL_CNT and BUBBLE_CNT.
// Ports:
//   CLK, RESET          clock and synchronous active-high reset
//   BUSYWAIT            global stall, freezes all state
//   FLUSH               drop every held entry and any concurrent accept
//   IN_VALID/IN_READY   upstream handshake; IN_CTRL/IN_DATA upstream bundles
//   OUT_VALID/OUT_READY downstream handshake; OUT_CTRL/OUT_DATA main entry
//   STALL_CNT/BUBBLE_CNT saturating counters (PIPE_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BUSYWAIT,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [CTRL_W-1:0] IN_CTRL,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [DATA_W-1:0] OUT_DATA
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  BUBBLE_CNT
`endif
);

  logic [1:0]        state_r,     state_nxt_s;
  logic              out_valid_r, out_valid_nxt_s;
  logic [CTRL_W-1:0] main_ctrl_r, main_ctrl_nxt_s;
  logic [DATA_W-1:0] main_data_r, main_data_nxt_s;
  logic [CTRL_W-1:0] skid_ctrl_r, skid_ctrl_nxt_s;
  logic [DATA_W-1:0] skid_data_r, skid_data_nxt_s;
  logic              skid_valid_s;
  logic              in_ready_s;
  logic              acc_s;
  logic              rel_s;

  // Bit 1 covers SKID and the illegal encoding, so upstream is held off
  // while the stage recovers from a corrupted state.
  assign skid_valid_s = state_r[1];
  assign in_ready_s   = ~skid_valid_s & ~BUSYWAIT & ~RESET;
  assign acc_s        = IN_VALID & in_ready_s;
  assign rel_s        = out_valid_r & OUT_READY & ~BUSYWAIT;

  // Next-state and entry movement for the stage.
  always_comb begin
    state_nxt_s     = state_r;
    out_valid_nxt_s = out_valid_r;
    main_ctrl_nxt_s = main_ctrl_r;
    main_data_nxt_s = main_data_r;
    skid_ctrl_nxt_s = skid_ctrl_r;
    skid_data_nxt_s = skid_data_r;
    if (FLUSH) begin
      // Data bundles stay stale; only control is scrubbed.
      state_nxt_s     = ST_EMPTY;
      out_valid_nxt_s = 1'b0;
      main_ctrl_nxt_s = '0;
      skid_ctrl_nxt_s = '0;
    end else if (BUSYWAIT) begin
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (acc_s) begin
            state_nxt_s     = ST_FULL;
            out_valid_nxt_s = 1'b1;
            main_ctrl_nxt_s = IN_CTRL;
            main_data_nxt_s = IN_DATA;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (acc_s && rel_s) begin
            main_ctrl_nxt_s = IN_CTRL;
            main_data_nxt_s = IN_DATA;
          end else if (acc_s) begin
            state_nxt_s     = ST_SKID;
            skid_ctrl_nxt_s = IN_CTRL;
            skid_data_nxt_s = IN_DATA;
          end else if (rel_s) begin
            state_nxt_s     = ST_EMPTY;
            out_valid_nxt_s = 1'b0;
            main_ctrl_nxt_s = '0;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        ST_SKID: begin
          if (rel_s) begin
            state_nxt_s     = ST_FULL;
            main_ctrl_nxt_s = skid_ctrl_r;
            main_data_nxt_s = skid_data_r;
            skid_ctrl_nxt_s = '0;
          end else begin
            state_nxt_s = ST_SKID;
          end
        end
        default: begin
          state_nxt_s     = ST_EMPTY;
          out_valid_nxt_s = 1'b0;
          main_ctrl_nxt_s = '0;
          skid_ctrl_nxt_s = '0;
        end
      endcase
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      main_ctrl_r <= '0;
      main_data_r <= '0;
      skid_ctrl_r <= '0;
      skid_data_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      main_ctrl_r <= main_ctrl_nxt_s;
      main_data_r <= main_data_nxt_s;
      skid_ctrl_r <= skid_ctrl_nxt_s;
      skid_data_r <= skid_data_nxt_s;
    end
  end

  assign IN_READY  = in_ready_s;
  assign OUT_VALID = out_valid_r;
  assign OUT_CTRL  = main_ctrl_r;
  assign OUT_DATA  = main_data_r;

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc_s;
  logic bubble_inc_s;

  // RESET clears the counters inside the counter, so no RESET term here.
  assign stall_inc_s  = BUSYWAIT & out_valid_r;
  assign bubble_inc_s = ~out_valid_r;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (stall_inc_s),
    .COUNT (STALL_CNT)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (bubble_inc_s),
    .COUNT (BUBBLE_CNT)
  );
`else
  localparam int unsigned cnt_w_unused = CNT_W;
`endif

endmodule
